translate_seg7: RTL and testbench

- Registered 4-bit to 7-segment display decoder.
- Converts a BCD digit (0-9), or optionally a hex nibble (A-F), into segment drive for one display digit.
- Sits between the digit counter/mux and the display pins.
- Output is registered: one clock of latency.

---
 rtl/translate_pkg.sv | 35 +++
 rtl/seg7_lut.sv | 47 ++++
 rtl/translate_seg7.sv | 60 ++++++
 tb/tb_translate_seg7.sv | 109 ++++++++++
 4 files changed

// File: rtl/translate_pkg.sv
// rtl/translate_pkg.sv - shared segment constants for the 7-segment decoder
package translate_pkg;

    localparam int SEG_BIT_A = 0;
    localparam int SEG_BIT_B = 1;
    localparam int SEG_BIT_C = 2;
    localparam int SEG_BIT_D = 3;
    localparam int SEG_BIT_E = 4;
    localparam int SEG_BIT_F = 5;
    localparam int SEG_BIT_G = 6;

    // Active-high patterns, bit 0 = segment a ... bit 6 = segment g
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    localparam logic [6:0] SEG_OFF = 7'h00;
    localparam logic [6:0] SEG_ALL = 7'((1 << SEG_BIT_A) | (1 << SEG_BIT_B) | (1 << SEG_BIT_C) |
                                        (1 << SEG_BIT_D) | (1 << SEG_BIT_E) | (1 << SEG_BIT_F) |
                                        (1 << SEG_BIT_G));

endpackage

// File: rtl/seg7_lut.sv
// rtl/seg7_lut.sv - combinational digit code to active-high segment pattern
module seg7_lut
    import translate_pkg::*;
#(
    parameter bit HEX_EN = 1'b0
) (
    input  logic [3:0] code_i,
    output logic [6:0] pat_o,
    output logic       invalid_o
);

    logic [6:0] hex_pat;

    always_comb begin
        hex_pat = SEG_OFF;
        case (code_i)
            4'h0: hex_pat = SEG_0;
            4'h1: hex_pat = SEG_1;
            4'h2: hex_pat = SEG_2;
            4'h3: hex_pat = SEG_3;
            4'h4: hex_pat = SEG_4;
            4'h5: hex_pat = SEG_5;
            4'h6: hex_pat = SEG_6;
            4'h7: hex_pat = SEG_7;
            4'h8: hex_pat = SEG_8;
            4'h9: hex_pat = SEG_9;
            4'hA: hex_pat = SEG_A;
            4'hB: hex_pat = SEG_B;
            4'hC: hex_pat = SEG_C;
            4'hD: hex_pat = SEG_D;
            4'hE: hex_pat = SEG_E;
            4'hF: hex_pat = SEG_F;
            default: hex_pat = SEG_OFF;
        endcase
    end

    // Codes above 9 are letters only in hex mode; in BCD mode they blank and flag
    always_comb begin
        pat_o     = hex_pat;
        invalid_o = 1'b0;
        if (!HEX_EN && (code_i > 4'd9)) begin
            pat_o     = SEG_OFF;
            invalid_o = 1'b1;
        end
    end

endmodule

// File: rtl/translate_seg7.sv
// rtl/translate_seg7.sv - registered 4-bit to 7-segment decoder with blank/lamp test
module translate_seg7
    import translate_pkg::*;
#(
    parameter bit HEX_EN     = 1'b0,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] in,
    input  logic       blank,
    input  logic       lamp_test,
    output logic [6:0] out,
    output logic       err
);

    localparam logic [6:0] OUT_OFF = ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;

    logic [6:0] lut_pat;
    logic       lut_invalid;
    logic [6:0] pat;
    logic [6:0] out_d, out_q;
    logic       err_d, err_q;

    seg7_lut #(
        .HEX_EN(HEX_EN)
    ) u_lut (
        .code_i   (in),
        .pat_o    (lut_pat),
        .invalid_o(lut_invalid)
    );

    // Priority below reset: lamp test, then blank, then the decoded digit
    always_comb begin
        pat   = lut_pat;
        err_d = lut_invalid;
        if (lamp_test) begin
            pat   = SEG_ALL;
            err_d = 1'b0;
        end else if (blank) begin
            pat   = SEG_OFF;
            err_d = 1'b0;
        end
        out_d = ACTIVE_LOW ? ~pat : pat;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_q <= OUT_OFF;
            err_q <= 1'b0;
        end else begin
            out_q <= out_d;
            err_q <= err_d;
        end
    end

    assign out = out_q;
    assign err = err_q;

endmodule

// File: tb/tb_translate_seg7.sv
// tb/tb_translate_seg7.sv - scoreboard bench for BCD/active-high and hex/active-low builds
module tb_translate_seg7;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] in = 4'd8;
    logic       blank = 1'b0;
    logic       lamp_test = 1'b0;
    logic [6:0] out0, out1;
    logic       err0, err1;

    typedef struct {
        logic [6:0] o0;
        logic       e0;
        logic [6:0] o1;
        logic       e1;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    always #5 clock = ~clock;

    translate_seg7 #(.HEX_EN(1'b0), .ACTIVE_LOW(1'b0)) dut0 (
        .clock(clock), .reset(reset), .in(in), .blank(blank),
        .lamp_test(lamp_test), .out(out0), .err(err0)
    );

    translate_seg7 #(.HEX_EN(1'b1), .ACTIVE_LOW(1'b1)) dut1 (
        .clock(clock), .reset(reset), .in(in), .blank(blank),
        .lamp_test(lamp_test), .out(out1), .err(err1)
    );

    task automatic step(input logic r, input logic lt, input logic bl, input logic [3:0] code,
                        input logic [6:0] o0, input logic e0,
                        input logic [6:0] o1, input logic e1, input string name);
        exp_t e;
        @(negedge clock);
        reset = r; lamp_test = lt; blank = bl; in = code;
        e.o0 = o0; e.e0 = e0; e.o1 = o1; e.e1 = e1; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: outputs are valid every cycle after the edge that sampled a vector
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk({e.name, " bcd.out"}, out0, e.o0);
                chk({e.name, " bcd.err"}, {6'd0, err0}, {6'd0, e.e0});
                chk({e.name, " hexal.out"}, out1, e.o1);
                chk({e.name, " hexal.err"}, {6'd0, err1}, {6'd0, e.e1});
            end
        end
    end

    initial begin
        step(1, 0, 0, 4'd8, 7'h00, 0, 7'h7F, 0, "reset1");
        step(1, 0, 0, 4'd8, 7'h00, 0, 7'h7F, 0, "reset2");
        step(0, 0, 0, 4'd0, 7'h3F, 0, 7'h40, 0, "sweep0");
        step(0, 0, 0, 4'd1, 7'h06, 0, 7'h79, 0, "sweep1");
        step(0, 0, 0, 4'd2, 7'h5B, 0, 7'h24, 0, "sweep2");
        step(0, 0, 0, 4'd3, 7'h4F, 0, 7'h30, 0, "sweep3");
        step(0, 0, 0, 4'd4, 7'h66, 0, 7'h19, 0, "sweep4");
        step(0, 0, 0, 4'd5, 7'h6D, 0, 7'h12, 0, "sweep5");
        step(0, 0, 0, 4'd6, 7'h7D, 0, 7'h02, 0, "sweep6");
        step(0, 0, 0, 4'd7, 7'h07, 0, 7'h78, 0, "sweep7");
        step(0, 0, 0, 4'd8, 7'h7F, 0, 7'h00, 0, "sweep8");
        step(0, 0, 0, 4'd9, 7'h6F, 0, 7'h10, 0, "sweep9");
        step(0, 0, 0, 4'd0, 7'h3F, 0, 7'h40, 0, "wrap0");
        step(0, 0, 0, 4'd10, 7'h00, 1, 7'h08, 0, "code10");
        step(0, 0, 0, 4'd15, 7'h00, 1, 7'h0E, 0, "code15");
        step(0, 0, 0, 4'd3, 7'h4F, 0, 7'h30, 0, "after_inv");
        step(0, 0, 0, 4'd11, 7'h00, 1, 7'h03, 0, "code11");
        step(0, 0, 0, 4'd12, 7'h00, 1, 7'h46, 0, "code12");
        step(0, 0, 0, 4'd13, 7'h00, 1, 7'h21, 0, "code13");
        step(0, 0, 0, 4'd14, 7'h00, 1, 7'h06, 0, "code14");
        step(0, 0, 1, 4'd5, 7'h00, 0, 7'h7F, 0, "blank5");
        step(0, 1, 1, 4'd5, 7'h7F, 0, 7'h00, 0, "lamp5");
        step(0, 1, 0, 4'd12, 7'h7F, 0, 7'h00, 0, "lamp_inv");
        step(0, 0, 1, 4'd12, 7'h00, 0, 7'h7F, 0, "blank_inv");
        step(0, 0, 0, 4'd10, 7'h00, 1, 7'h08, 0, "code10b");
        step(1, 1, 1, 4'd5, 7'h00, 0, 7'h7F, 0, "reset_wins");
        step(0, 0, 0, 4'd1, 7'h06, 0, 7'h79, 0, "pol1");
        step(0, 0, 0, 4'd8, 7'h7F, 0, 7'h00, 0, "pol8");
        repeat (3) @(negedge clock);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
